// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Holds the FSM state enumeration and the default word width.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-offer handshake between a producer and the serializer.
// master: drives iDATA/iVALID/iLSB_FIRST, sees oREADY; slave: the reverse.
interface bit_serializer_if #(
   parameter int WIDTH = 8
) ();

   logic [WIDTH-1:0] iDATA;
   logic             iVALID;
   logic             iLSB_FIRST;
   logic             oREADY;

   modport master (
      output iDATA,
      output iVALID,
      output iLSB_FIRST,
      input  oREADY
   );

   modport slave (
      input  iDATA,
      input  iVALID,
      input  iLSB_FIRST,
      output oREADY
   );

endinterface

// File: rtl/bit_serializer_hold.sv
// One-entry holding register in front of the shifter.
// Ports: iCLK/iRST, iWR (accept), iRD (drain to shifter), iDATA/iLSB in,
// oFULL/oDATA/oLSB out, oREADY = not full (registered).
module bit_serializer_hold #(
   parameter int WIDTH = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iWR,
   input  logic             iRD,
   input  logic [WIDTH-1:0] iDATA,
   input  logic             iLSB,
   output logic             oFULL,
   output logic [WIDTH-1:0] oDATA,
   output logic             oLSB,
   output logic             oREADY
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic             r_lsb;

   // iWR only fires when empty and iRD only when full,
   // so the two never coincide.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_full <= 1'b0;
         r_data <= '0;
         r_lsb  <= 1'b0;
      end else if (iWR) begin
         r_full <= 1'b1;
         r_data <= iDATA;
         r_lsb  <= iLSB;
      end else if (iRD) begin
         r_full <= 1'b0;
      end
   end

   assign oFULL  = r_full;
   assign oDATA  = r_data;
   assign oLSB   = r_lsb;
   assign oREADY = ~r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, one bit per clock, per-word bit order.
// Ports: iCLK, iRST (async low), s_if (word handshake), oOUT/oACTIVE/oDONE.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             iCLK,
   input  logic             iRST,
   bit_serializer_if.slave  s_if,
   output logic             oOUT,
   output logic             oACTIVE,
   output logic             oDONE
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_lsb;

   logic             w_ready;
   logic             w_accept;
   logic             w_full;
   logic [WIDTH-1:0] w_hdata;
   logic             w_hlsb;
   logic             w_last;
   logic             w_load;

   assign w_accept    = s_if.iVALID & w_ready;
   assign s_if.oREADY = w_ready;

   bit_serializer_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iWR    (w_accept),
      .iRD    (w_load),
      .iDATA  (s_if.iDATA),
      .iLSB   (s_if.iLSB_FIRST),
      .oFULL  (w_full),
      .oDATA  (w_hdata),
      .oLSB   (w_hlsb),
      .oREADY (w_ready)
   );

   assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

   // Load on the idle edge or on the edge that ends the last bit,
   // which keeps consecutive words gap-free.
   assign w_load = w_full && ((r_state == IDLE) || w_last);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (w_full)            w_next = SHIFT;
         SHIFT: if (w_last && !w_full) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      oOUT    = 1'b0;
      oACTIVE = 1'b0;
      oDONE   = 1'b0;
      if (r_state == SHIFT) begin
         oACTIVE = 1'b1;
         oOUT    = r_lsb ? r_shift[0] : r_shift[WIDTH-1];
         oDONE   = w_last;
      end
   end

   // The current bit always sits at one end of the shifter;
   // the shift direction follows the captured bit order.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_lsb   <= 1'b0;
      end else if (w_load) begin
         r_shift <= w_hdata;
         r_lsb   <= w_hlsb;
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         if (w_last) begin
            r_shift <= '0;
            r_cnt   <= '0;
         end else begin
            r_shift <= r_lsb ? (r_shift >> 1) : (r_shift << 1);
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

endmodule
